// File: rtl/mult_pkg.sv
// Shared state encoding and default sizing for the multiplier initiator.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package mult_pkg;

   localparam int MULT_WIDTH_DEF   = 5;
   localparam int MULT_DEPTH_DEF   = 4;
   localparam int MULT_TIMEOUT_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_OUT  = 2'd3
   } mult_state_e;

endpackage

// File: rtl/mult_op_fifo.sv
// Operand-pair FIFO: DEPTH entries of {a, b}, head visible combinationally.
// Latency: a pushed pair is at the head on the cycle after the push edge.
// Backpressure: full_o blocks pushes; push and pop in one cycle both take effect.
module mult_op_fifo import mult_pkg::*; #(
   parameter int WIDTH = MULT_WIDTH_DEF,
   parameter int DEPTH = MULT_DEPTH_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               push_i,
   input  logic [2*WIDTH-1:0] push_dat_i,
   input  logic               pop_i,
   output logic [2*WIDTH-1:0] head_dat_o,
   output logic               full_o,
   output logic               empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [2*WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]        wr_ptr_q, wr_ptr_d;
   logic [AW:0]        rd_ptr_q, rd_ptr_d;
   logic               do_push, do_pop;

   // The extra pointer MSB tells a full ring from an empty one
   assign empty_o    = (wr_ptr_q == rd_ptr_q);
   assign full_o     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head_dat_o = mem_q[rd_ptr_q[AW-1:0]];

   assign do_push  = push_i && !full_o;
   assign do_pop   = pop_i && !empty_o;
   assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
   assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

   // Pointer registers; reset empties the FIFO
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage needs no reset: entries are only read between push and pop
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= push_dat_i;
      end
   end

endmodule

// File: rtl/mult_initiator.sv
// Queues operand pairs and drives them one at a time through a req/rdy multiplier, holding each product until consumed.
// Latency: in_valid -> req 2 cycles minimum; done -> out_valid 1 cycle. Optional WAIT watchdog under MULT_TIMEOUT_EN.
// Backpressure: in_ready = FIFO not full; a result stays in OUT (out_ab stable) until out_ready.
module mult_initiator import mult_pkg::*; #(
   parameter int WIDTH          = MULT_WIDTH_DEF,
   parameter int DEPTH          = MULT_DEPTH_DEF,
   parameter int TIMEOUT_CYCLES = MULT_TIMEOUT_DEF
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   in_a,
   input  logic [WIDTH-1:0]   in_b,
   output logic               req,
   input  logic               rdy,
   output logic [WIDTH-1:0]   a,
   output logic [WIDTH-1:0]   b,
   input  logic               done,
   input  logic [2*WIDTH-1:0] ab,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] out_ab,
   output logic               busy,
   output logic               timeout_err
);

   mult_state_e        state_q, state_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
   logic [2*WIDTH-1:0] out_ab_q, out_ab_d;
   logic [2*WIDTH-1:0] head_dat;
   logic               fifo_full, fifo_empty, fifo_pop;
   logic               tmo_hit;

   mult_op_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_op_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_i     (in_valid && in_ready),
      .push_dat_i ({in_a, in_b}),
      .pop_i      (fifo_pop),
      .head_dat_o (head_dat),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty)
   );

   assign in_ready  = !fifo_full;
   assign req       = (state_q == ST_REQ);
   assign out_valid = (state_q == ST_OUT);
   assign busy      = (state_q != ST_IDLE) || !fifo_empty;
   assign a         = a_q;
   assign b         = b_q;
   assign out_ab    = out_ab_q;

`ifdef MULT_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

   logic [CW-1:0] wait_cnt_q, wait_cnt_d;
   logic          timeout_err_q, timeout_err_d;

   // Counter runs only while waiting for done and restarts on every new WAIT
   assign tmo_hit       = (state_q == ST_WAIT) && !done &&
                          (wait_cnt_q == CW'(TIMEOUT_CYCLES - 1));
   assign wait_cnt_d    = (state_q == ST_WAIT) ? wait_cnt_q + 1'b1 : '0;
   assign timeout_err_d = timeout_err_q || tmo_hit;
   assign timeout_err   = timeout_err_q;

   // Watchdog count and sticky error flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt_q    <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         wait_cnt_q    <= wait_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end
`else
   assign tmo_hit     = 1'b0;
   assign timeout_err = 1'b0;
`endif

   // Next state, operand load on pop, product capture on done
   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      out_ab_d = out_ab_q;
      fifo_pop = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               fifo_pop   = 1'b1;
               {a_d, b_d} = head_dat;
               state_d    = ST_REQ;
            end
         end
         ST_REQ: begin
            if (rdy) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            // done outside WAIT is never looked at, so stray pulses are harmless
            if (done) begin
               out_ab_d = ab;
               state_d  = ST_OUT;
            end else if (tmo_hit) begin
               state_d  = ST_IDLE;
            end
         end
         ST_OUT: begin
            if (out_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         out_ab_q <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         out_ab_q <= out_ab_d;
      end
   end

endmodule
